// File: rtl/cost_engine_sched_if.sv
// cost_engine_sched_if: requester-side and engine-side signals of the shared
// cost engine scheduler. The scheduler connects through the slave modport;
// the requesters plus the engine (or a bench standing in for them) use master.
interface cost_engine_sched_if #(
  parameter int NUM_REQ    = 4,
  parameter int BIT_WIDTH  = 16,
  parameter int BLOCK_SIZE = 8
);
  localparam int LVL_W = BIT_WIDTH * 16 * BLOCK_SIZE;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LVL_W-1:0] req_levels;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [31:0]              resp_sum;
  logic                     resp_err;
  logic                     busy;
  logic                     eng_start;
  logic [LVL_W-1:0]         eng_levels;
  logic                     eng_done;
  logic [31:0]              eng_sum;

  modport slave (
    input  req, req_levels, eng_done, eng_sum,
    output gnt, resp_valid, resp_sum, resp_err, busy, eng_start, eng_levels
  );

  modport master (
    output req, req_levels, eng_done, eng_sum,
    input  gnt, resp_valid, resp_sum, resp_err, busy, eng_start, eng_levels
  );
endinterface

// File: rtl/cost_engine_sched.sv
// cost_engine_sched: shares one sum-of-squares cost engine among NUM_REQ
// requesters. Pending requests are picked round-robin, the winner's level
// vector is muxed onto the engine, one start pulse is issued, and the engine
// result is returned with a one-hot, one-cycle response pulse.
//
// Build option: define COST_SCHED_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES (response with resp_err=1, resp_sum=0) and to discard the
// first engine done that arrives after such an abort.
//
// state | meaning
// IDLE  | sample req, pick next requester scanning up from rr_ptr
// GRANT | one cycle, eng_start high, gnt held
// WAIT  | waiting for eng_done (or timeout when enabled)
// RESP  | one cycle, resp_valid[gnt_idx] high, then release grant
module cost_engine_sched #(
  parameter int NUM_REQ        = 4,
  parameter int BIT_WIDTH      = 16,
  parameter int BLOCK_SIZE     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cost_engine_sched_if.slave   bus
);

  localparam int LVL_W = BIT_WIDTH * 16 * BLOCK_SIZE;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("cost_engine_sched: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W-1:0]   w_rr_nxt;
  logic               w_pick_vld;
  logic [NUM_REQ-1:0] w_pick_oh;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [31:0]        r_resp_sum;
  logic               r_eng_start;
  logic               w_done;
  logic               w_timeout;
  logic               w_to_resp;
  logic [LVL_W-1:0]   w_slice [NUM_REQ];

  // Split the packed request levels into one slice per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_slice[g] = bus.req_levels[g*LVL_W +: LVL_W];
  end

  // Round-robin pick: descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    logic [IDX_W-1:0] v_idx;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    v_idx      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v_idx = IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (bus.req[v_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = v_idx;
      end
    end
  end

  assign w_pick_oh = NUM_REQ'(1) << w_pick_idx;
  assign w_rr_nxt  = (r_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode; a done in GRANT is a zero-latency completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_vld) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = w_done ? S_RESP : S_WAIT;
      S_WAIT:  if (w_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_to_resp = ((r_state == S_GRANT) || (r_state == S_WAIT)) &&
                     (w_state_nxt == S_RESP);

  // Grant, start pulse, response pulse and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr     <= '0;
      r_gnt_idx    <= '0;
      r_gnt        <= '0;
      r_resp_valid <= '0;
      r_resp_sum   <= '0;
      r_eng_start  <= 1'b0;
    end else begin
      r_eng_start  <= 1'b0;
      r_resp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_gnt_idx   <= w_pick_idx;
            r_gnt       <= w_pick_oh;
            r_eng_start <= 1'b1;
          end
        end
        S_RESP: begin
          r_gnt    <= '0;
          r_rr_ptr <= w_rr_nxt;
        end
        default: ;
      endcase
      if (w_to_resp) begin
        r_resp_valid <= r_gnt;
        r_resp_sum   <= w_done ? bus.eng_sum : 32'd0;
      end
    end
  end

`ifdef COST_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_stale;
  logic             r_resp_err;

  // A done owed to an aborted request is swallowed once.
  assign w_done    = bus.eng_done & ~r_stale;
  assign w_timeout = (r_state == S_WAIT) && (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // WAIT timeout counter, stale-done flag and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt  <= '0;
      r_stale    <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      if (r_state == S_GRANT)     r_tmo_cnt <= '0;
      else if (r_state == S_WAIT) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_timeout && !w_done)   r_stale <= 1'b1;
      else if (bus.eng_done)      r_stale <= 1'b0;
      if (w_to_resp)              r_resp_err <= ~w_done;
    end
  end

  assign bus.resp_err = r_resp_err;
`else
  assign w_done       = bus.eng_done;
  assign w_timeout    = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  assign bus.gnt        = r_gnt;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_sum   = r_resp_sum;
  assign bus.eng_start  = r_eng_start;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.eng_levels = (r_state == S_IDLE) ? '0 : w_slice[r_gnt_idx];

endmodule

// File: tb/tb_cost_engine_sched.sv
// Directed bench for cost_engine_sched: a behavioural sum-of-squares engine
// with programmable latency answers each start; requests are driven per the
// requester contract and grant/response timing, order and sums are compared
// against hand-computed values.
module tb_cost_engine_sched;
  localparam int NR = 4;
  localparam int BW = 16;
  localparam int BS = 8;
  localparam int TO = 16;
  localparam int LW = BW * 16 * BS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cost_engine_sched_if #(.NUM_REQ(NR), .BIT_WIDTH(BW), .BLOCK_SIZE(BS)) u_if ();

  cost_engine_sched #(
    .NUM_REQ(NR), .BIT_WIDTH(BW), .BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int n_err = 0;
  int n_chk = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model: sum of squares of the levels seen at start, done after m_lat cycles.
  int          m_lat = 3;
  bit          m_en  = 1'b1;
  int          m_cnt = -1;
  int          m_acc = 0;
  int          m_cf  = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_sum  = '0;
  logic        stray_done = 1'b0;
  logic [31:0] stray_sum  = '0;

  assign u_if.eng_done = m_done | stray_done;
  assign u_if.eng_sum  = stray_done ? stray_sum : m_sum;

  always @(negedge clk) begin
    m_done = 1'b0;
    if (u_if.eng_start && m_en) begin
      m_acc = 0;
      for (int i = 0; i < 16 * BS; i++) begin
        m_cf  = int'($signed(u_if.eng_levels[i*BW +: BW]));
        m_acc = m_acc + m_cf * m_cf;
      end
      if (m_lat == 0) begin
        m_done = 1'b1;
        m_sum  = 32'(m_acc);
        m_cnt  = -1;
      end else begin
        m_cnt = m_lat;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_done = 1'b1;
        m_sum  = 32'(m_acc);
        m_cnt  = -1;
      end
    end
  end

  // Per-service records filled by serve().
  int          g_cyc [8];
  int          r_cyc [8];
  logic [3:0]  g_gnt [8];
  logic [15:0] g_lv0 [8];
  logic [3:0]  r_vec [8];
  logic [31:0] r_sum [8];
  logic        r_err [8];

  task automatic set_all(input int r, input int v);
    for (int i = 0; i < 16 * BS; i++) u_if.req_levels[r*LW + i*BW +: BW] = 16'(v);
  endtask

  task automatic set_lv(input int r, input int c0, input int c1, input int c2);
    u_if.req_levels[r*LW +: LW] = '0;
    u_if.req_levels[r*LW + 0*BW +: BW] = 16'(c0);
    u_if.req_levels[r*LW + 1*BW +: BW] = 16'(c1);
    u_if.req_levels[r*LW + 2*BW +: BW] = 16'(c2);
  endtask

  // Call at posedge+1; that cycle is cycle 0. Serves n responses, dropping each
  // requester's bit in the IDLE cycle after its response. Optional stray done
  // is driven for the whole of cycle stray_at.
  task automatic serve(input logic [NR-1:0] rq, input int n, input int stray_at,
                       input logic [31:0] s_sum);
    int c = 0;
    int k = 0;
    logic [NR-1:0] drop;
    u_if.req  = rq;
    stray_sum = s_sum;
    while (k < n && c < 300) begin
      @(negedge clk);
      drop = '0;
      if (u_if.eng_start && k < 8) begin
        g_cyc[k] = c;
        g_gnt[k] = u_if.gnt;
        g_lv0[k] = u_if.eng_levels[15:0];
      end
      if (|u_if.resp_valid) begin
        if (k < 8) begin
          r_cyc[k] = c;
          r_vec[k] = u_if.resp_valid;
          r_sum[k] = u_if.resp_sum;
          r_err[k] = u_if.resp_err;
        end
        drop = u_if.resp_valid;
        k++;
      end
      @(posedge clk); #1;
      u_if.req = u_if.req & ~drop;
      c++;
      stray_done = (c == stray_at);
    end
    stray_done = 1'b0;
    check("serve_resp_count", 64'(k), 64'(n));
  endtask

  task automatic do_reset();
    u_if.req = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] oh;
    int pulses;
    int busy_cnt;

    u_if.req        = '0;
    u_if.req_levels = '0;
    do_reset();

    // Reset state.
    @(negedge clk);
    check("rst_gnt",        64'(u_if.gnt),        64'd0);
    check("rst_resp_valid", 64'(u_if.resp_valid), 64'd0);
    check("rst_resp_sum",   64'(u_if.resp_sum),   64'd0);
    check("rst_resp_err",   64'(u_if.resp_err),   64'd0);
    check("rst_eng_start",  64'(u_if.eng_start),  64'd0);
    check("rst_busy",       64'(u_if.busy),       64'd0);
    check("rst_eng_levels", 64'(u_if.eng_levels == '0), 64'd1);
    @(posedge clk); #1;

    // Single requester 1, levels all 3, latency 9: 128*9 = 1152.
    set_all(1, 3);
    m_lat = 9;
    serve(4'b0010, 1, -1, 32'd0);
    check("single_start_cyc", 64'(g_cyc[0]), 64'd1);
    check("single_gnt",       64'(g_gnt[0]), 64'b0010);
    check("single_lvl0",      64'(g_lv0[0]), 64'd3);
    check("single_resp_cyc",  64'(r_cyc[0]), 64'd11);
    check("single_resp_vec",  64'(r_vec[0]), 64'b0010);
    check("single_sum",       64'(r_sum[0]), 64'd1152);
    check("single_err",       64'(r_err[0]), 64'd0);
    @(negedge clk);
    check("idle_busy",   64'(u_if.busy), 64'd0);
    check("idle_gnt",    64'(u_if.gnt),  64'd0);
    check("idle_levels", 64'(u_if.eng_levels == '0), 64'd1);
    @(posedge clk); #1;

    // rr_ptr is now 2: req 0011 wraps to requester 0 (sum 9+1), then 1.
    set_lv(0, 3, 1, 0);
    m_lat = 2;
    serve(4'b0011, 2, -1, 32'd0);
    check("wrap_first_gnt",  64'(g_gnt[0]), 64'b0001);
    check("wrap_second_gnt", 64'(g_gnt[1]), 64'b0010);
    check("wrap_first_sum",  64'(r_sum[0]), 64'd10);
    check("wrap_second_sum", 64'(r_sum[1]), 64'd1152);

    // All four from cycle 0 after reset: sums 10,20,30,40 in order 0..3.
    do_reset();
    set_lv(1, 4, 2, 0);
    set_lv(2, 5, 2, 1);
    set_lv(3, 6, 2, 0);
    m_lat = 3;
    serve(4'b1111, 4, -1, 32'd0);
    check("rr_first_start", 64'(g_cyc[0]), 64'd1);
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      check("rr_gnt",      64'(g_gnt[k]), 64'(oh));
      check("rr_resp_vec", 64'(r_vec[k]), 64'(oh));
      check("rr_sum",      64'(r_sum[k]), 64'(10 * (k + 1)));
      if (k < 3) check("rr_resp_to_grant", 64'(g_cyc[k+1] - r_cyc[k]), 64'd2);
    end

    // Zero-latency engine: requester 2 with sum 4+1.
    set_lv(2, 2, 1, 0);
    m_lat = 0;
    serve(4'b0100, 1, -1, 32'd0);
    check("zl_start_cyc", 64'(g_cyc[0]), 64'd1);
    check("zl_resp_cyc",  64'(r_cyc[0]), 64'd2);
    check("zl_sum",       64'(r_sum[0]), 64'd5);

    // Stray done in IDLE must be ignored.
    stray_sum  = 32'd77;
    stray_done = 1'b1;
    pulses   = 0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (|u_if.resp_valid) pulses++;
      if (u_if.busy) busy_cnt++;
      @(posedge clk); #1;
      stray_done = 1'b0;
    end
    check("stray_idle_resp", 64'(pulses),        64'd0);
    check("stray_idle_busy", 64'(busy_cnt),      64'd0);
    check("stray_idle_sum",  64'(u_if.resp_sum), 64'd5);

    // Reset pulsed during WAIT: silent abort, late done ignored, then normal service.
    m_lat = 20;
    u_if.req = 4'b0001;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_busy_before", 64'(u_if.busy), 64'd1);
    check("midrst_gnt_before",  64'(u_if.gnt),  64'b0001);
    #1 rst_n = 1'b0;
    u_if.req = '0;
    #1;
    check("midrst_gnt",       64'(u_if.gnt),        64'd0);
    check("midrst_busy",      64'(u_if.busy),       64'd0);
    check("midrst_start",     64'(u_if.eng_start),  64'd0);
    check("midrst_resp",      64'(u_if.resp_valid), 64'd0);
    check("midrst_sum",       64'(u_if.resp_sum),   64'd0);
    check("midrst_levels",    64'(u_if.eng_levels == '0), 64'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (|u_if.resp_valid) pulses++;
      @(posedge clk); #1;
    end
    check("midrst_no_resp", 64'(pulses), 64'd0);
    m_lat = 4;
    serve(4'b0001, 1, -1, 32'd0);
    check("postrst_start_cyc", 64'(g_cyc[0]), 64'd1);
    check("postrst_resp_cyc",  64'(r_cyc[0]), 64'd6);
    check("postrst_resp_vec",  64'(r_vec[0]), 64'b0001);
    check("postrst_sum",       64'(r_sum[0]), 64'd10);

`ifdef COST_SCHED_TIMEOUT_EN
    // Engine never answers: abort after 16 WAIT cycles (cycles 2..17).
    m_en = 1'b0;
    serve(4'b0001, 1, -1, 32'd0);
    check("tmo_resp_cyc", 64'(r_cyc[0]), 64'd18);
    check("tmo_err",      64'(r_err[0]), 64'd1);
    check("tmo_sum",      64'(r_sum[0]), 64'd0);
    // Late done lands in the next request's WAIT and must be discarded.
    m_en  = 1'b1;
    m_lat = 6;
    serve(4'b0001, 1, 3, 32'd777);
    check("tmo_next_resp_cyc", 64'(r_cyc[0]), 64'd8);
    check("tmo_next_sum",      64'(r_sum[0]), 64'd10);
    check("tmo_next_err",      64'(r_err[0]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
